// File: rtl/task_4_output_pkg.sv
// Shared types and constants for the task 4 output stage.
package task_4_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_PREFETCH = 2'd2,
        S_SEND     = 2'd3
    } task_4_output_state_t;

endpackage

// File: rtl/task_4_output_fifo.sv
// Single-clock byte FIFO with a registered read port (q valid the cycle after rdreq).
module task_4_output_fifo
    import task_4_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic              clock,
    input  logic [BYTE_W-1:0] data,
    input  logic              wrreq,
    input  logic              rdreq,
    input  logic              sclr,
    output logic              empty,
    output logic              full,
    output logic [BYTE_W-1:0] q
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [BYTE_W-1:0] mem [DEPTH];
    logic              do_wr;
    logic              do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr = wrreq && !full;
    assign do_rd = rdreq && !empty;

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= data;
        end
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q      <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) begin
                q      <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/task_4_output.sv
// Task 4 output stage: buffers one burst of strobed bytes as a frame and replays it
// as an AXI-Stream master with tlast on the final byte.
module task_4_output
    import task_4_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [BYTE_W-1:0]    i_data,
    input  logic                 i_enb,
    output logic                 o_tvalid,
    output logic [BYTE_W-1:0]    o_tdata,
    output logic                 o_tlast,
    input  logic                 i_tready,
    output logic                 o_busy,
    output logic                 o_overflow,
    output logic [15:0]          o_frame_cnt,
    output task_4_output_state_t o_state
);

    // Handshake: a beat transfers on a clock edge where o_tvalid && i_tready. Once
    // o_tvalid is raised, o_tdata/o_tlast hold until that beat transfers; o_tvalid
    // never depends combinationally on i_tready.

    task_4_output_state_t state;
    task_4_output_state_t state_nxt;

    logic [CNT_W-1:0]  len;
    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  unread;
    logic              wrreq;
    logic              rdreq;
    logic              drop;
    logic              beat;
    logic              last_beat;
    logic              fifo_empty;
    logic              fifo_full;
    logic [BYTE_W-1:0] fifo_q;

    assign beat      = o_tvalid && i_tready;
    assign last_beat = beat && (rem == CNT_W'(1));
    assign o_busy    = (state != S_IDLE);
    assign o_state   = state;
    // The FIFO's registered q is the output holding register; it only advances on rdreq.
    assign o_tdata   = fifo_q;

    task_4_output_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock (i_clk),
        .data  (i_data),
        .wrreq (wrreq),
        .rdreq (rdreq),
        .sclr  (!i_rst_n),
        .empty (fifo_empty),
        .full  (fifo_full),
        .q     (fifo_q)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wrreq     = 1'b0;
        rdreq     = 1'b0;
        drop      = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_enb) begin
                    wrreq     = 1'b1;
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (i_enb) begin
                    if ((len < CNT_W'(DEPTH)) && !fifo_full) begin
                        wrreq = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else begin
                    state_nxt = S_PREFETCH;
                end
            end
            S_PREFETCH: begin
                rdreq     = 1'b1;
                drop      = i_enb;
                state_nxt = S_SEND;
            end
            S_SEND: begin
                // Refill the holding register whenever it is empty or being drained.
                rdreq = (unread != '0) && !fifo_empty && (!o_tvalid || i_tready);
                drop  = i_enb;
                if (last_beat) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            len         <= '0;
            rem         <= '0;
            unread      <= '0;
            o_tvalid    <= 1'b0;
            o_tlast     <= 1'b0;
            o_overflow  <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            if (drop) begin
                o_overflow <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (i_enb) begin
                        len <= CNT_W'(1);
                    end
                end
                S_COLLECT: begin
                    if (wrreq) begin
                        len <= len + CNT_W'(1);
                    end
                end
                S_PREFETCH: begin
                    rem      <= len;
                    unread   <= len - CNT_W'(1);
                    o_tvalid <= 1'b1;
                    o_tlast  <= (len == CNT_W'(1));
                end
                S_SEND: begin
                    if (rdreq) begin
                        unread   <= unread - CNT_W'(1);
                        o_tvalid <= 1'b1;
                        o_tlast  <= (unread == CNT_W'(1));
                    end else if (beat) begin
                        o_tvalid <= 1'b0;
                        o_tlast  <= 1'b0;
                    end
                    if (beat) begin
                        rem <= rem - CNT_W'(1);
                    end
                    if (last_beat) begin
                        o_frame_cnt <= o_frame_cnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_task_4_output.sv
// Directed bench for task_4_output: framing, backpressure, overflow and reset cases.
module tb_task_4_output;
    import task_4_pkg::*;

    localparam int DEPTH = 16;

    logic                 i_clk;
    logic                 i_rst_n;
    logic [7:0]           i_data;
    logic                 i_enb;
    logic                 o_tvalid;
    logic [7:0]           o_tdata;
    logic                 o_tlast;
    logic                 i_tready;
    logic                 o_busy;
    logic                 o_overflow;
    logic [15:0]          o_frame_cnt;
    task_4_output_state_t o_state;

    int errors = 0;
    int checks = 0;
    int beats  = 0;
    int b0;
    logic [8:0] exp_q[$];

    task_4_output #(.DEPTH(DEPTH)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_data      (i_data),
        .i_enb       (i_enb),
        .o_tvalid    (o_tvalid),
        .o_tdata     (o_tdata),
        .o_tlast     (o_tlast),
        .i_tready    (i_tready),
        .o_busy      (o_busy),
        .o_overflow  (o_overflow),
        .o_frame_cnt (o_frame_cnt),
        .o_state     (o_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        i_enb  = 1'b1;
        i_data = b;
        tick();
    endtask

    task automatic push(input logic [7:0] b, input logic last);
        exp_q.push_back({last, b});
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_enb   = 1'b0;
        tick();
        chk("rst_tvalid", o_tvalid, 0);
        chk("rst_tlast", o_tlast, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_overflow", o_overflow, 0);
        chk("rst_tdata", o_tdata, 0);
        chk("rst_frame_cnt", o_frame_cnt, 0);
        chk("rst_state", 32'(o_state), 32'(S_IDLE));
        i_rst_n = 1'b1;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating.
    task automatic drain(input int mode, input int budget);
        logic       pv, pr, pl;
        logic [7:0] pd;
        bit         done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            pv = o_tvalid;
            pd = o_tdata;
            pl = o_tlast;
            i_tready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            pr = i_tready;
            tick();
            if (pv && !pr) begin
                chk("stall_tdata", o_tdata, pd);
                chk("stall_tlast", o_tlast, pl);
                chk("stall_tvalid", o_tvalid, 1);
            end
            if (!o_busy) done = 1'b1;
        end
        chk("drain_timeout", done, 1);
        i_tready = 1'b1;
    endtask

    // Scoreboard: every transferred beat must match the head of exp_q.
    always @(negedge i_clk) begin
        if (o_tvalid === 1'b1 && i_tready === 1'b1) begin
            beats++;
            if (exp_q.size() == 0) begin
                chk("beat_expected", 0, 1);
            end else begin
                chk("beat", {23'd0, o_tlast, o_tdata}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n  = 1'b0;
        i_enb    = 1'b0;
        i_data   = 8'h00;
        i_tready = 1'b1;
        tick();
        do_reset();

        // 4-byte frame, ready held high: exact cycle timing
        push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h44, 1);
        drive_byte(8'h11);
        chk("t1_busy_after_first", o_busy, 1);
        drive_byte(8'h22); drive_byte(8'h33); drive_byte(8'h44);
        i_enb = 1'b0;
        tick();
        chk("t1_prefetch_tvalid", o_tvalid, 0);
        chk("t1_prefetch_state", 32'(o_state), 32'(S_PREFETCH));
        tick();
        chk("t1_b1_tvalid", o_tvalid, 1);
        chk("t1_b1_tdata", o_tdata, 8'h11);
        chk("t1_b1_tlast", o_tlast, 0);
        tick();
        chk("t1_b2_tdata", o_tdata, 8'h22);
        tick();
        chk("t1_b3_tdata", o_tdata, 8'h33);
        chk("t1_b3_tlast", o_tlast, 0);
        tick();
        chk("t1_b4_tdata", o_tdata, 8'h44);
        chk("t1_b4_tlast", o_tlast, 1);
        tick();
        chk("t1_busy_end", o_busy, 0);
        chk("t1_tvalid_end", o_tvalid, 0);
        chk("t1_frame_cnt", o_frame_cnt, 1);
        chk("t1_q_empty", exp_q.size(), 0);

        // Same frame under toggling backpressure
        b0 = beats;
        push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h44, 1);
        drive_byte(8'h11); drive_byte(8'h22); drive_byte(8'h33); drive_byte(8'h44);
        i_enb = 1'b0;
        drain(1, 60);
        chk("t2_beats", beats - b0, 4);
        chk("t2_frame_cnt", o_frame_cnt, 2);
        chk("t2_q_empty", exp_q.size(), 0);

        // DEPTH+3 bytes: only DEPTH emitted, overflow sticky
        b0 = beats;
        for (int k = 0; k < DEPTH + 3; k++) begin
            if (k < DEPTH) push(8'hA0 + 8'(k), k == DEPTH - 1);
            drive_byte(8'hA0 + 8'(k));
            if (k == DEPTH - 1) chk("t3_no_overflow_at_depth", o_overflow, 0);
        end
        chk("t3_overflow_set", o_overflow, 1);
        i_enb = 1'b0;
        drain(0, 60);
        chk("t3_beats", beats - b0, DEPTH);
        chk("t3_overflow_sticky", o_overflow, 1);
        chk("t3_frame_cnt", o_frame_cnt, 3);
        chk("t3_q_empty", exp_q.size(), 0);

        // Strobe during S_SEND is dropped, frame intact
        do_reset();
        b0 = beats;
        push(8'hC1, 0); push(8'hC2, 0); push(8'hC3, 1);
        drive_byte(8'hC1); drive_byte(8'hC2); drive_byte(8'hC3);
        i_enb = 1'b0;
        tick();
        tick();
        chk("t4_send_tdata", o_tdata, 8'hC1);
        i_enb  = 1'b1;
        i_data = 8'hEE;
        tick();
        i_enb = 1'b0;
        chk("t4_overflow", o_overflow, 1);
        drain(0, 20);
        chk("t4_beats", beats - b0, 3);
        chk("t4_frame_cnt", o_frame_cnt, 1);
        chk("t4_q_empty", exp_q.size(), 0);

        // 1-byte frame, then a 2-byte frame starting on the first idle cycle
        do_reset();
        push(8'h55, 1);
        drive_byte(8'h55);
        i_enb = 1'b0;
        tick();
        tick();
        chk("t5_single_tvalid", o_tvalid, 1);
        chk("t5_single_tdata", o_tdata, 8'h55);
        chk("t5_single_tlast", o_tlast, 1);
        tick();
        chk("t5_idle_busy", o_busy, 0);
        chk("t5_cnt_first", o_frame_cnt, 1);
        push(8'h66, 0); push(8'h77, 1);
        drive_byte(8'h66); drive_byte(8'h77);
        i_enb = 1'b0;
        drain(0, 20);
        chk("t5_frame_cnt", o_frame_cnt, 2);
        chk("t5_overflow", o_overflow, 0);
        chk("t5_q_empty", exp_q.size(), 0);

        // Reset during S_SEND with two beats still outstanding
        do_reset();
        push(8'h81, 0); push(8'h82, 0);
        drive_byte(8'h81); drive_byte(8'h82); drive_byte(8'h83); drive_byte(8'h84);
        i_enb = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_pre_rst_tdata", o_tdata, 8'h82);
        do_reset();
        chk("t6_q_empty_rst", exp_q.size(), 0);
        b0 = beats;
        push(8'h91, 0); push(8'h92, 0); push(8'h93, 1);
        drive_byte(8'h91); drive_byte(8'h92); drive_byte(8'h93);
        i_enb = 1'b0;
        drain(0, 20);
        chk("t6_beats", beats - b0, 3);
        chk("t6_frame_cnt", o_frame_cnt, 1);
        chk("t6_q_empty", exp_q.size(), 0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
